store_write_buffer: RTL and testbench

//  FIFO write buffer between the CPU memory stage and a slower external data bus.
//  - Absorbs stores (memwrite / aluout / writedata) at up to one per cycle.
//  - Drains them in order over a valid/ready bus handshake.
//  - Stalls the pipeline only when the buffer is full, or when load ordering demands it.
//  - Keeps the data path single-cycle for the CPU while dmem/peripherals sit behind wait states.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/wbuf_fwd_match.sv | 39 +++
 rtl/store_write_buffer.sv | 106 ++++++++++
 tb/tb_store_write_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the store write buffer.
package cpu_pkg;

  localparam int unsigned WBUF_DEPTH = 4;
  localparam int unsigned WBUF_AW    = 32;
  localparam int unsigned WBUF_DW    = 32;

  typedef struct packed {
    logic [WBUF_AW-1:0] addr;
    logic [WBUF_DW-1:0] data;
  } wbuf_entry_t;

  function automatic logic [WBUF_AW-1:0] word_align(input logic [WBUF_AW-1:0] a);
    return {a[WBUF_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wbuf_fwd_match.sv
// Load-forwarding lookup over the buffered stores; only present with STORE_BUF_FWD_EN.
`ifdef STORE_BUF_FWD_EN
module wbuf_fwd_match
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH,
  parameter int unsigned AW    = WBUF_AW,
  parameter int unsigned DW    = WBUF_DW,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  wbuf_entry_t      entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    rd_ptr,
  input  logic [AW-1:0]    lookup_addr,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [PW-1:0] idx;
  logic          unused_lsb;

  assign unused_lsb = ^lookup_addr[1:0];

  // Walk oldest to youngest so a later (younger) match overwrites an older one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (valid[idx] && entries[idx].addr == {lookup_addr[AW-1:2], 2'b00}) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule
`endif

// File: rtl/store_write_buffer.sv
// FIFO store buffer between the CPU memory stage and a wait-stated data bus.
// Optional load forwarding is enabled by defining STORE_BUF_FWD_EN.
module store_write_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH,
  parameter int unsigned AW    = WBUF_AW,
  parameter int unsigned DW    = WBUF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wbuf_entry_t   entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          enq;
  logic          deq;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign enq   = cpu_we & ~full;
  assign deq   = bus_valid & bus_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers and count alone define which slots are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[wr_ptr].addr <= word_align(cpu_addr);
      entries[wr_ptr].data <= cpu_wdata;
    end
  end

  assign bus_valid = ~empty;
  assign bus_addr  = empty ? '0 : entries[rd_ptr].addr;
  assign bus_wdata = empty ? '0 : entries[rd_ptr].data;

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] valid_mask;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  always_comb begin
    valid_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_mask[i] = CW'(PW'(PW'(i) - rd_ptr)) < count;
    end
  end

  wbuf_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .entries     (entries),
    .valid       (valid_mask),
    .rd_ptr      (rd_ptr),
    .lookup_addr (cpu_addr),
    .hit         (fwd_hit),
    .data        (fwd_data)
  );

  assign cpu_rdata = (cpu_re & fwd_hit) ? fwd_data : mem_rdata;
  assign cpu_stall = cpu_we & full;
`else
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];
  assign cpu_rdata       = mem_rdata;
  // Without forwarding a load must not overtake pending stores.
  assign cpu_stall       = (cpu_we & full) | (cpu_re & ~empty);
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized scoreboard bench for store_write_buffer against a queue-based model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re, bus_ready;
  logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
  logic [31:0] cpu_rdata, bus_addr, bus_wdata;
  logic        cpu_stall, bus_valid, empty;

  store_write_buffer #(
    .DEPTH (DEPTH),
    .AW    (32),
    .DW    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_rdata (mem_rdata),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];     // model: stores held in the buffer, oldest first
  ent_t        exp_q[$];  // scoreboard: beats the bus still owes us
  ent_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  int          ready_mode = 0;
  int          cyc = 0;
  bit          last_acc, last_stall;
  logic        exp_valid, exp_empty, exp_stall, exp_re;
  logic [31:0] exp_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [31:0] mem);
    logic [31:0] r;
    r = mem;
    if (FWD)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].a[31:2] == a[31:2]) r = mq[i].d;
    return r;
  endfunction

  function automatic logic pick_ready();
    case (ready_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return cyc[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic step(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    bit   deq;
    ent_t e;
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = a;
    cpu_wdata = d;
    mem_rdata = $urandom;
    bus_ready = pick_ready();
    exp_valid = (mq.size() > 0);
    exp_empty = (mq.size() == 0);
    exp_stall = (we && mq.size() == DEPTH) || (!FWD && re && mq.size() > 0);
    exp_re    = re;
    exp_rdata = model_load(a, mem_rdata);
    last_acc   = we && (mq.size() < DEPTH);
    last_stall = exp_stall;
    deq = bus_ready && (mq.size() > 0);
    @(posedge clk);
    cyc++;
    if (deq) e = mq.pop_front();
    e.a = {a[31:2], 2'b00};
    e.d = d;
    if (last_acc) begin
      mq.push_back(e);
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic store_retry(input logic [31:0] a, input logic [31:0] d, input string nm);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b0, a, d);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk({nm, "_accept_timeout"}, 64'(n), 64'(0));
  endtask

  task automatic drain(input string nm);
    ready_mode = 1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk({nm, "_bus_beats_outstanding"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // Monitor: compares live outputs against the model and pops each bus beat.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_valid", 64'(bus_valid), 64'(exp_valid));
      chk("empty", 64'(empty), 64'(exp_empty));
      chk("cpu_stall", 64'(cpu_stall), 64'(exp_stall));
      if (exp_re) chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
      if (bus_valid && bus_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bus_beat: got unexpected beat addr %0h expected none (cycle %0d)",
                   bus_addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_addr", 64'(bus_addr), 64'(mon_e.a));
          chk("bus_wdata", 64'(bus_wdata), 64'(mon_e.d));
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    cpu_we = 1'b0; cpu_re = 1'b0; bus_ready = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    cpu_we = 1'b1;
    #1;
    chk("reset_bus_valid", 64'(bus_valid), 64'(0));
    chk("reset_empty", 64'(empty), 64'(1));
    chk("reset_cpu_stall", 64'(cpu_stall), 64'(0));
    cpu_we = 1'b0;
    reset  = 1'b1;
    chk_en = 1'b1;

    // 1. reset with three stores pending
    ready_mode = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h100 + 32'(i * 4), $urandom);
    chk_en = 1'b0;
    reset  = 1'b0;
    cpu_we = 1'b1;
    #1;
    chk("midreset_bus_valid", 64'(bus_valid), 64'(0));
    chk("midreset_empty", 64'(empty), 64'(1));
    chk("midreset_cpu_stall", 64'(cpu_stall), 64'(0));
    chk("midreset_bus_addr", 64'(bus_addr), 64'(0));
    chk("midreset_bus_wdata", 64'(bus_wdata), 64'(0));
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    cpu_we = 1'b0;
    chk_en = 1'b1;
    ready_mode = 1;
    step(1'b1, 1'b0, 32'h10, 32'hAA);
    drain("t1");

    // 2. stream with bus_ready held high
    ready_mode = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), $urandom);
    drain("t2");

    // 3. fill with bus stalled, then release it under a pending store
    ready_mode = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'hF0 + 32'(i));
    step(1'b1, 1'b0, 32'h210, 32'hF4);
    chk("t3_fifth_stalled", 64'(last_acc), 64'(0));
    ready_mode = 1;
    store_retry(32'h210, 32'hF4, "t3");
    drain("t3");

    // 4. wrap with bus_ready toggling
    ready_mode = 2;
    for (int i = 0; i < 10; i++) store_retry(32'h300 + 32'(i * 4), $urandom, "t4");
    drain("t4");

    // 5. load to an address with pending stores
    ready_mode = 0;
    step(1'b1, 1'b0, 32'h20, 32'h11);
    step(1'b1, 1'b0, 32'h20, 32'h22);
    begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        ready_mode = (i >= 2) ? 1 : 0;
        step(1'b0, 1'b1, 32'h20, 32'h0);
        done = !last_stall;
      end
      if (!done) chk("t5_load_timeout", 64'(0), 64'(1));
    end
    drain("t5");

    // 6. enqueue and dequeue in the same cycle
    ready_mode = 0;
    step(1'b1, 1'b0, 32'h400, 32'h1);
    step(1'b1, 1'b0, 32'h404, 32'h2);
    ready_mode = 1;
    step(1'b1, 1'b0, 32'h408, 32'h3);
    ready_mode = 0;
    step(1'b1, 1'b0, 32'h40C, 32'h4);
    step(1'b1, 1'b0, 32'h410, 32'h5);
    step(1'b1, 1'b0, 32'h414, 32'h6);
    chk("t6_full_after_pair", 64'(last_acc), 64'(0));
    drain("t6");

    // random traffic
    ready_mode = 3;
    for (int i = 0; i < 300; i++) begin
      bit we, re;
      we = 1'($urandom_range(0, 1));
      re = !we && ($urandom_range(0, 3) == 0);
      step(we, re, {27'($urandom_range(0, 7)), 2'b00, 2'($urandom)} , $urandom);
    end
    drain("rand");

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
